ultrasonic_ranger: RTL and testbench



---
 rtl/ultrasonic_pkg.sv | 37 +++
 rtl/us_tick_gen.sv | 41 ++++
 rtl/ultrasonic_ranger.sv | 201 ++++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// ---------------------------------------------------------------------------
// ultrasonic_pkg
// Shared definitions for the ultrasonic ranging peripheral:
//   - state_e         : measurement sequencer states
//   - ADDR_*          : byte addresses of the bus-visible registers
//   - CTRL_* / STAT_* : bit positions inside the CTRL and STATUS registers
//   - sat_inc()       : 16-bit increment that sticks at 0xFFFF
// ---------------------------------------------------------------------------
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_DONE
    } state_e;

    localparam logic [3:0] ADDR_CTRL    = 4'd0;
    localparam logic [3:0] ADDR_STATUS  = 4'd2;
    localparam logic [3:0] ADDR_DIST_US = 4'd4;
    localparam logic [3:0] ADDR_DIST_CM = 4'd6;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;

    // Counters saturate rather than wrap so an overlong echo can never
    // masquerade as a short one.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// ---------------------------------------------------------------------------
// us_tick_gen
// Prescaler counting 0..MAX-1 on every enabled cycle; tick is high for the
// enabled cycle in which the count sits at its terminal value.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  synchronous reset, active-low
//   clr   in  synchronous clear back to 0 (wins over en)
//   en    in  count enable
//   tick  out terminal-count pulse, one enabled cycle wide
// ---------------------------------------------------------------------------
module us_tick_gen #(
    parameter int unsigned MAX = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ultrasonic_ranger.sv
// ---------------------------------------------------------------------------
// ultrasonic_ranger
// HC-SR04-style ranging peripheral on the j1soc peripheral bus. A CTRL start
// write fires a trigger pulse, then the echo high time is measured in
// microseconds and centimetres, with busy/done/timeout status.
// Ports:
//   sys_clk_i  in  system clock, rising edge
//   sys_rst_i  in  synchronous reset, active-low
//   cs_i       in  peripheral select
//   rd_i       in  read strobe (qualified by cs_i)
//   wr_i       in  write strobe (qualified by cs_i)
//   addr_i     in  byte address: 0 CTRL, 2 STATUS, 4 DIST_US, 6 DIST_CM
//   d_in_i     in  write data (CTRL bit0 start, bit1 abort)
//   d_out_o    out registered read data, valid 1 cycle after cs_i & rd_i
//   echo_i     in  sensor echo, asynchronous
//   trig_o     out sensor trigger
//   busy_o     out measurement in progress
// ---------------------------------------------------------------------------
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 30000,
    parameter int US_PER_CM   = 58
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        cs_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [3:0]  addr_i,
    input  logic [15:0] d_in_i,
    output logic [15:0] d_out_o,
    input  logic        echo_i,
    output logic        trig_o,
    output logic        busy_o
);

    localparam int CLK_PER_US = CLK_FREQ_HZ / 1000000;
    localparam logic [15:0] TRIG_LAST    = 16'(TRIG_US - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_US - 1);

    state_e      state_q, state_d;
    logic        echo_meta, echo_s, echo_prev;
    logic        rise, fall;
    logic        state_entry;
    logic        us_tick, cm_tick;
    logic [15:0] ph_cnt, us_cnt, cm_cnt;
    logic [15:0] us_cnt_nxt, cm_cnt_nxt;
    logic [15:0] dist_us, dist_cm;
    logic        done_q, timeout_q;
    logic        wr_ctrl, start_req, abort_req, rd_cm;
    logic        go, finish, expire;
    logic        unused_bits;

    assign unused_bits = ^d_in_i[15:2];

    assign wr_ctrl   = cs_i && wr_i && (addr_i == ADDR_CTRL);
    assign start_req = wr_ctrl && d_in_i[CTRL_START];
    assign abort_req = wr_ctrl && d_in_i[CTRL_ABORT];
    assign rd_cm     = cs_i && rd_i && (addr_i == ADDR_DIST_CM);

    assign rise = echo_s && !echo_prev;
    assign fall = !echo_s && echo_prev;

    assign trig_o = (state_q == ST_TRIG);
    assign busy_o = (state_q != ST_IDLE);

    // Both prescalers restart on every state change so each phase is timed
    // from its own first cycle.
    assign state_entry = (state_d != state_q);

    us_tick_gen #(.MAX(CLK_PER_US)) u_us_tick (
        .clk   (sys_clk_i),
        .rst_n (sys_rst_i),
        .clr   (state_entry),
        .en    (1'b1),
        .tick  (us_tick)
    );

    us_tick_gen #(.MAX(US_PER_CM)) u_cm_tick (
        .clk   (sys_clk_i),
        .rst_n (sys_rst_i),
        .clr   (state_entry),
        .en    (us_tick && (state_q == ST_MEASURE)),
        .tick  (cm_tick)
    );

    // Results latched on the falling edge include a tick landing in that
    // same cycle, so an echo of exactly N us reports N.
    assign us_cnt_nxt = us_tick ? sat_inc(us_cnt) : us_cnt;
    assign cm_cnt_nxt = cm_tick ? sat_inc(cm_cnt) : cm_cnt;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        finish  = 1'b0;
        expire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d = ST_TRIG;
                    go      = 1'b1;
                end
            end
            ST_TRIG: begin
                if (us_tick && ph_cnt == TRIG_LAST) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                end else if (us_tick && ph_cnt == TIMEOUT_LAST) begin
                    state_d = ST_DONE;
                    expire  = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (fall) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end else if (us_tick && us_cnt == TIMEOUT_LAST) begin
                    state_d = ST_DONE;
                    expire  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything, including a start in the same write.
        if (abort_req) begin
            state_d = ST_IDLE;
            go      = 1'b0;
            finish  = 1'b0;
            expire  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            state_q   <= ST_IDLE;
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_prev <= 1'b0;
            ph_cnt    <= '0;
            us_cnt    <= '0;
            cm_cnt    <= '0;
            dist_us   <= '0;
            dist_cm   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            echo_meta <= echo_i;
            echo_s    <= echo_meta;
            echo_prev <= echo_s;

            if (state_entry) ph_cnt <= '0;
            else if (us_tick) ph_cnt <= sat_inc(ph_cnt);

            if (go) begin
                us_cnt <= '0;
                cm_cnt <= '0;
            end else if (state_q == ST_MEASURE) begin
                us_cnt <= us_cnt_nxt;
                cm_cnt <= cm_cnt_nxt;
            end

            if (expire) begin
                dist_us <= 16'hFFFF;
                dist_cm <= 16'hFFFF;
            end else if (finish) begin
                dist_us <= us_cnt_nxt;
                dist_cm <= cm_cnt_nxt;
            end

            if (expire) timeout_q <= 1'b1;
            else if (go) timeout_q <= 1'b0;

            // Setting done wins over the DIST_CM read-clear in the same cycle.
            if (finish || expire) done_q <= 1'b1;
            else if (go || abort_req || rd_cm) done_q <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            d_out_o <= '0;
        end else if (cs_i && rd_i) begin
            case (addr_i)
                ADDR_STATUS:  d_out_o <= {13'd0, timeout_q, done_q, busy_o};
                ADDR_DIST_US: d_out_o <= dist_us;
                ADDR_DIST_CM: d_out_o <= dist_cm;
                default:      d_out_o <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// ---------------------------------------------------------------------------
// tb_ultrasonic_ranger
// Self-checking bench for ultrasonic_ranger. Uses a scaled clock (5 cycles
// per microsecond) and a short timeout so the timeout paths stay quick.
// Expected distances come from the plain arithmetic model
// us = echo_cycles / CLK_PER_US, cm = us / US_PER_CM.
// ---------------------------------------------------------------------------
module tb_ultrasonic_ranger;
    import ultrasonic_pkg::*;

    localparam int CLK_FREQ_HZ = 5000000;
    localparam int TRIG_US     = 10;
    localparam int TIMEOUT_US  = 2000;
    localparam int US_PER_CM   = 58;
    localparam int CPU         = CLK_FREQ_HZ / 1000000;

    logic        clk, rst_n, cs, rd, wr, echo, trig, busy;
    logic [3:0]  addr;
    logic [15:0] d_in, d_out;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] prev_us, prev_cm;

    ultrasonic_ranger #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TRIG_US     (TRIG_US),
        .TIMEOUT_US  (TIMEOUT_US),
        .US_PER_CM   (US_PER_CM)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst_n),
        .cs_i      (cs),
        .rd_i      (rd),
        .wr_i      (wr),
        .addr_i    (addr),
        .d_in_i    (d_in),
        .d_out_o   (d_out),
        .echo_i    (echo),
        .trig_o    (trig),
        .busy_o    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [3:0] a, input logic [15:0] data);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = data;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; d_in = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] data);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        data = d_out;
    endtask

    // Start a measurement; returns at the first cycle with trig low.
    task automatic start_and_trig(output int trig_len);
        bus_write(ADDR_CTRL, 16'h0001);
        trig_len = 0;
        while (trig === 1'b1 && trig_len < 100000) begin
            trig_len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int limit, output int cycles, output bit ok);
        cycles = 0;
        while (busy === 1'b1 && cycles < limit) begin
            cycles++;
            @(negedge clk);
        end
        ok = (busy === 1'b0);
    endtask

    // Full measurement with echo rising `delay` cycles after trigger ends
    // and staying high `width` cycles.
    task automatic run_echo(input int delay, input int width, output bit ok);
        int tl, cyc;
        start_and_trig(tl);
        repeat (delay) @(negedge clk);
        echo = 1'b1;
        repeat (width) @(negedge clk);
        echo = 1'b0;
        wait_idle(100, cyc, ok);
    endtask

    task automatic test_reset;
        logic [15:0] r;
        repeat (3) @(negedge clk);
        n_cmp++; if (trig !== 1'b0) begin n_bad++; $display("FAIL reset_trig: got %b want 0", trig); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (d_out !== 16'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0000", d_out); end
        rst_n = 1'b1;
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 16'h0) begin n_bad++; $display("FAIL reset_status: got %h want 0000", r); end
        bus_read(ADDR_DIST_US, r);
        n_cmp++; if (r !== 16'h0) begin n_bad++; $display("FAIL reset_dist_us: got %h want 0000", r); end
    endtask

    task automatic test_nominal;
        int tl, cyc;
        bit ok;
        logic [15:0] r;
        bus_write(ADDR_CTRL, 16'h0001);
        n_cmp++; if (trig !== 1'b1) begin n_bad++; $display("FAIL nominal_trig_start: got %b want 1", trig); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nominal_busy: got %b want 1", busy); end
        tl = 0;
        while (trig === 1'b1 && tl < 100000) begin
            tl++;
            @(negedge clk);
        end
        n_cmp++; if (tl != TRIG_US * CPU) begin n_bad++; $display("FAIL nominal_trig_len: got %0d want %0d", tl, TRIG_US * CPU); end
        repeat (100 * CPU) @(negedge clk);
        echo = 1'b1;
        repeat (580 * CPU) @(negedge clk);
        echo = 1'b0;
        wait_idle(100, cyc, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL nominal_finish: got busy=%b want 0", busy); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 16'h0002) begin n_bad++; $display("FAIL nominal_status: got %h want 0002", r); end
        bus_read(ADDR_DIST_US, r);
        n_cmp++; if (r !== 16'd580) begin n_bad++; $display("FAIL nominal_dist_us: got %0d want 580", r); end
        bus_read(ADDR_DIST_CM, r);
        n_cmp++; if (r !== 16'd10) begin n_bad++; $display("FAIL nominal_dist_cm: got %0d want 10", r); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 16'h0000) begin n_bad++; $display("FAIL nominal_status_cleared: got %h want 0000", r); end
        prev_us = 16'd580;
        prev_cm = 16'd10;
    endtask

    task automatic test_no_echo;
        int tl, cyc;
        bit ok;
        logic [15:0] r;
        start_and_trig(tl);
        // WAIT_RISE lasts TIMEOUT_US microseconds, then one DONE cycle.
        wait_idle(TIMEOUT_US * CPU + 100, cyc, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL no_echo_finish: got busy=%b want 0", busy); end
        n_cmp++; if (cyc != TIMEOUT_US * CPU + 1) begin n_bad++; $display("FAIL no_echo_duration: got %0d want %0d", cyc, TIMEOUT_US * CPU + 1); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 16'h0006) begin n_bad++; $display("FAIL no_echo_status: got %h want 0006", r); end
        bus_read(ADDR_DIST_US, r);
        n_cmp++; if (r !== 16'hFFFF) begin n_bad++; $display("FAIL no_echo_dist_us: got %h want ffff", r); end
        bus_read(ADDR_DIST_CM, r);
        n_cmp++; if (r !== 16'hFFFF) begin n_bad++; $display("FAIL no_echo_dist_cm: got %h want ffff", r); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 16'h0004) begin n_bad++; $display("FAIL no_echo_status_after_read: got %h want 0004", r); end
    endtask

    task automatic test_echo_stuck;
        int tl, cyc;
        bit ok;
        logic [15:0] r;
        start_and_trig(tl);
        echo = 1'b1;
        wait_idle(TIMEOUT_US * CPU + 100, cyc, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stuck_finish: got busy=%b want 0", busy); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 16'h0006) begin n_bad++; $display("FAIL stuck_status: got %h want 0006", r); end
        bus_read(ADDR_DIST_US, r);
        n_cmp++; if (r !== 16'hFFFF) begin n_bad++; $display("FAIL stuck_dist_us: got %h want ffff", r); end
        echo = 1'b0;
        repeat (5) @(negedge clk);
        run_echo(20, 200 * CPU, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL restart_finish: got busy=%b want 0", busy); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 16'h0002) begin n_bad++; $display("FAIL restart_status: got %h want 0002", r); end
        bus_read(ADDR_DIST_US, r);
        n_cmp++; if (r !== 16'd200) begin n_bad++; $display("FAIL restart_dist_us: got %0d want 200", r); end
        bus_read(ADDR_DIST_CM, r);
        n_cmp++; if (r !== 16'd3) begin n_bad++; $display("FAIL restart_dist_cm: got %0d want 3", r); end
        prev_us = 16'd200;
        prev_cm = 16'd3;
    endtask

    task automatic test_busy_start_abort;
        int tl, hi;
        logic [15:0] r;
        start_and_trig(tl);
        bus_write(ADDR_CTRL, 16'h0001);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (trig === 1'b1) hi++;
            @(negedge clk);
        end
        n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL busy_start_retrig: got %0d trig cycles want 0", hi); end
        echo = 1'b1;
        repeat (10) @(negedge clk);
        bus_write(ADDR_CTRL, 16'h0002);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 16'h0000) begin n_bad++; $display("FAIL abort_status: got %h want 0000", r); end
        bus_read(ADDR_DIST_US, r);
        n_cmp++; if (r !== prev_us) begin n_bad++; $display("FAIL abort_dist_us: got %0d want %0d", r, prev_us); end
        bus_read(ADDR_DIST_CM, r);
        n_cmp++; if (r !== prev_cm) begin n_bad++; $display("FAIL abort_dist_cm: got %0d want %0d", r, prev_cm); end
        echo = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (d_out !== prev_cm) begin n_bad++; $display("FAIL dout_hold: got %0d want %0d", d_out, prev_cm); end
    endtask

    task automatic test_ignored_writes;
        logic [15:0] r;
        bus_write(ADDR_STATUS, 16'h0001);
        bus_write(ADDR_DIST_US, 16'h0001);
        bus_write(ADDR_DIST_CM, 16'h0001);
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || trig !== 1'b0) begin n_bad++; $display("FAIL ignored_writes: got busy=%b trig=%b want 0 0", busy, trig); end
        bus_read(ADDR_DIST_US, r);
        n_cmp++; if (r !== prev_us) begin n_bad++; $display("FAIL ignored_dist_us: got %0d want %0d", r, prev_us); end
        bus_read(4'd8, r);
        n_cmp++; if (r !== 16'h0000) begin n_bad++; $display("FAIL unmapped_read: got %h want 0000", r); end
    endtask

    task automatic test_random;
        int width, delay;
        bit ok;
        logic [15:0] r, exp_us, exp_cm;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: width = CPU - 1;                    // under one microsecond
                1: width = US_PER_CM * CPU * 3 - 1;    // one cycle short of 3 cm
                2: width = US_PER_CM * CPU * 3;        // exactly 3 cm
                3: width = CPU * 999 + 3;
                default: width = int'($urandom_range(CPU * 1200, 1));
            endcase
            delay = int'($urandom_range(200, 0));
            exp_us = 16'(width / CPU);
            exp_cm = 16'((width / CPU) / US_PER_CM);
            run_echo(delay, width, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_finish: got busy=%b want 0", k, busy); end
            bus_read(ADDR_STATUS, r);
            n_cmp++; if (r !== 16'h0002) begin n_bad++; $display("FAIL rand%0d_status: got %h want 0002", k, r); end
            bus_read(ADDR_DIST_US, r);
            n_cmp++; if (r !== exp_us) begin n_bad++; $display("FAIL rand%0d_dist_us (width %0d): got %0d want %0d", k, width, r, exp_us); end
            bus_read(ADDR_DIST_CM, r);
            n_cmp++; if (r !== exp_cm) begin n_bad++; $display("FAIL rand%0d_dist_cm (width %0d): got %0d want %0d", k, width, r, exp_cm); end
            prev_us = exp_us;
            prev_cm = exp_cm;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        int tl;
        logic [15:0] r;
        start_and_trig(tl);
        echo = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 16'h0001) begin n_bad++; $display("FAIL measure_status: got %h want 0001", r); end
        bus_read(ADDR_DIST_US, r);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (trig !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midreset_outputs: got trig=%b busy=%b want 0 0", trig, busy); end
        n_cmp++; if (d_out !== 16'h0) begin n_bad++; $display("FAIL midreset_dout: got %h want 0000", d_out); end
        rst_n = 1'b1;
        echo = 1'b0;
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 16'h0000) begin n_bad++; $display("FAIL midreset_status: got %h want 0000", r); end
        bus_read(ADDR_DIST_CM, r);
        n_cmp++; if (r !== 16'h0000) begin n_bad++; $display("FAIL midreset_dist_cm: got %h want 0000", r); end
    endtask

    initial begin
        rst_n = 1'b0;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = '0; d_in = '0; echo = 1'b0;
        prev_us = '0; prev_cm = '0;
        test_reset();
        test_nominal();
        test_no_echo();
        test_echo_stuck();
        test_busy_start_abort();
        test_ignored_writes();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
